// File: rtl/psg_sn76489.sv
// psg_sn76489: SN76489-compatible sound generator with three square-wave tone
// channels, one LFSR noise channel, 4-bit attenuation per channel, and a
// registered unsigned mix.
// Optional build macro PSG_READY_EN: each accepted write holds ready low for
// READY_CYCLES clocks. Writes offered while ready is low are dropped.
//
// Write handshake: a byte on din is accepted on any rising clock_in edge where
// we=1 and ready=1. Its effect is visible after that edge. When we=1 and
// ready=0, the write has no effect. Without PSG_READY_EN, ready is always 1.
module psg_sn76489 #(
    parameter int READY_CYCLES = 32,
    parameter int MIX_W        = 10
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             snd_tick,
    input  logic             we,
    input  logic [7:0]       din,
    output logic             ready,
    output logic [MIX_W-1:0] audio,
    output logic [3:0]       ch_out
);

`ifdef PSG_READY_EN
    localparam bit READY_EN = 1'b1;
`else
    localparam bit READY_EN = 1'b0;
`endif
    localparam int BUSY_W = $clog2(READY_CYCLES + 1);
    localparam logic [14:0] LFSR_SEED = 15'h4000;

    logic [BUSY_W-1:0] busy;
    logic              wr;
    logic [1:0]        wr_ch;
    logic              wr_att;
    logic              nz_wr;
    logic [2:0]        sel;
    logic [9:0]        period [3];
    logic [9:0]        cnt    [3];
    logic [2:0]        tone;
    logic [3:0]        att    [4];
    logic [2:0]        nctrl;
    logic [14:0]       lfsr;
    logic [14:0]       lfsr_shifted;
    logic              fb;
    logic              noise_out;
    logic [5:0]        nz_cnt;
    logic [6:0]        nz_lim;
    logic              nz_wrap;
    logic              t2_rise;
    logic              shift;
    logic [9:0]        mix_sum;

    // Amplitude for a 4-bit attenuation code. Code 15 is silence.
    function automatic logic [7:0] amp(input logic [3:0] a);
        case (a)
            4'd0:    amp = 8'd255;
            4'd1:    amp = 8'd203;
            4'd2:    amp = 8'd161;
            4'd3:    amp = 8'd128;
            4'd4:    amp = 8'd102;
            4'd5:    amp = 8'd81;
            4'd6:    amp = 8'd64;
            4'd7:    amp = 8'd51;
            4'd8:    amp = 8'd40;
            4'd9:    amp = 8'd32;
            4'd10:   amp = 8'd26;
            4'd11:   amp = 8'd20;
            4'd12:   amp = 8'd16;
            4'd13:   amp = 8'd13;
            4'd14:   amp = 8'd10;
            default: amp = 8'd0;
        endcase
    endfunction

    // Busy counter. It stays at zero unless the ready-throttle build is selected.
    always_ff @(posedge clock_in) begin
        if (reset)
            busy <= '0;
        else if (READY_EN && wr)
            busy <= BUSY_W'(READY_CYCLES);
        else if (busy != '0)
            busy <= busy - 1'b1;
    end

    assign ready = (busy == '0);
    assign wr    = we & ready;

    // Target decode. A latch byte names its own register. A data byte reuses the latched one.
    assign wr_ch  = din[7] ? din[6:5] : sel[2:1];
    assign wr_att = din[7] ? din[4]   : sel[0];
    assign nz_wr  = wr && !wr_att && (wr_ch == 2'd3);

    // Latched register select and attenuation registers.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            sel <= 3'b000;
            for (int i = 0; i < 4; i++) att[i] <= 4'hF;
        end else if (wr) begin
            if (din[7]) sel <= din[6:4];
            if (wr_att) att[wr_ch] <= din[3:0];
        end
    end

    // Tone generators. A tick uses the period held before any same-cycle write.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                period[k] <= '0;
                cnt[k]    <= '0;
            end
            tone <= 3'b111;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (snd_tick) begin
                    if (period[k] <= 10'd1) begin
                        cnt[k]  <= '0;
                        tone[k] <= 1'b1;
                    end else if (cnt[k] > 10'd1) begin
                        cnt[k] <= cnt[k] - 10'd1;
                    end else begin
                        cnt[k]  <= period[k];
                        tone[k] <= ~tone[k];
                    end
                end
                if (wr && !wr_att && (wr_ch == 2'(k))) begin
                    if (din[7]) period[k][3:0] <= din[3:0];
                    else        period[k][9:4] <= din[5:0];
                end
            end
        end
    end

    // Shift-clock sources: a tick divider for rates 0-2, and tone2 rising edges for rate 3.
    assign t2_rise = snd_tick && (period[2] > 10'd1) && (cnt[2] <= 10'd1) && !tone[2];

    always_comb begin
        nz_lim = 7'd64;
        case (nctrl[1:0])
            2'd0:    nz_lim = 7'd16;
            2'd1:    nz_lim = 7'd32;
            default: nz_lim = 7'd64;
        endcase
    end

    assign nz_wrap      = (7'(nz_cnt) + 7'd1) >= nz_lim;
    assign shift        = (nctrl[1:0] == 2'd3) ? t2_rise : (snd_tick && nz_wrap);
    assign fb           = nctrl[2] ? (lfsr[0] ^ lfsr[1]) : lfsr[0];
    assign lfsr_shifted = {fb, lfsr[14:1]};

    // Noise divider: counts ticks and wraps after the selected number of ticks.
    always_ff @(posedge clock_in) begin
        if (reset)
            nz_cnt <= '0;
        else if (snd_tick)
            nz_cnt <= nz_wrap ? 6'd0 : nz_cnt + 6'd1;
    end

    // Noise control and LFSR. A control write reseeds the LFSR. The all-zero state is never kept.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            nctrl     <= 3'b000;
            lfsr      <= LFSR_SEED;
            noise_out <= 1'b1;
        end else if (nz_wr) begin
            nctrl <= din[2:0];
            lfsr  <= LFSR_SEED;
        end else if (lfsr == '0) begin
            lfsr <= LFSR_SEED;
        end else if (shift) begin
            lfsr      <= lfsr_shifted;
            noise_out <= lfsr_shifted[0];
        end
    end

    assign ch_out = {noise_out, tone};

    // Sum of the amplitudes of the channels whose raw bit is high.
    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < 4; i++)
            if (ch_out[i]) mix_sum = mix_sum + 10'(amp(att[i]));
    end

    // Registered mix output.
    always_ff @(posedge clock_in) begin
        if (reset) audio <= '0;
        else       audio <= MIX_W'(mix_sum);
    end

endmodule

// File: doc/psg_sn76489.md
Name: psg_sn76489

Overview:
- Programmable sound generator compatible with the SN76489: three square-wave tone channels, one noise channel and 4-bit attenuation per channel.
- Sits directly downstream of the NTSC PLL block. It consumes the PLL's sound-rate clock as a one-cycle enable, derived by a synchronizer in the top level.
- Takes CPU byte writes and produces a mixed unsigned audio sample for the PWM/DAC stage.

Parameters:
- READY_CYCLES, 32: number of clock_in cycles that ready stays low after an accepted write. Used only with PSG_READY_EN.
- MIX_W, 10: width of the mixed audio output. Must be at least 10.

Ports:
- clock_in  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- snd_tick  input  1  one-cycle enable at the sound rate (447 kHz nominal); advances all generators.
- we  input  1  write strobe; a byte is accepted on any cycle with we=1 and ready=1.
- din  input  8  write data byte.
- ready  output  1  write-accept indication.
- audio  output  MIX_W  registered unsigned mix of the four channels.
- ch_out  output  4  raw channel bits before attenuation: {noise, tone2, tone1, tone0}.

Behaviour:
- Reset state:
  - tone periods = 0; tone counters = 0; tone outputs = 1.
  - attenuations = 4'hF (silent); noise control = 0; LFSR = 15'h4000; latched register = tone0.
  - prescaler = 0; audio = 0; ch_out = 4'b1111; ready = 1.
  - Reset wins over we and snd_tick in the same cycle.
- Write decode:
  - Latch byte (din[7]=1): select = din[6:5] (channel) plus din[4] (0 = tone/noise control, 1 = attenuation).
    - Tone: period[3:0] = din[3:0].
    - Attenuation: att = din[3:0].
    - Noise control (ch3, din[4]=0): ctrl = din[2:0], and the LFSR is reset to 15'h4000.
  - Data byte (din[7]=0): targets the currently latched register.
    - Tone: period[9:4] = din[5:0].
    - Attenuation: att = din[3:0].
    - Noise control: same effect as the latch form, including the LFSR reset.
  - A write takes effect on the next clock edge. Counters are not reloaded on a write; a new period applies at the next reload.
- Tone channel k, on each snd_tick:
  - If counter > 1: decrement the counter.
  - Otherwise: reload counter = period and toggle the output.
  - Period 0 or 1: output is forced to 1 and the counter is held at 0.
- Noise:
  - Shift clock from ctrl[1:0]: 00/01/10 → internal counter reloaded with 16/32/64 on snd_tick ticks; 11 → every rising edge of tone2's output.
  - On each shift: lfsr <= {fb, lfsr[14:1]}.
    - White (ctrl[2]=1): fb = lfsr[0]^lfsr[1].
    - Periodic (ctrl[2]=0): fb = lfsr[0].
  - Noise output = lfsr[0].
  - The LFSR is never all-zero. A zero value is reloaded as 15'h4000 (defensive).
- Mixing:
  - Amplitude LUT on att: 255,203,161,128,102,81,64,51,40,32,26,20,16,13,10,0.
  - audio <= sum over the four channels of (ch_out[i] ? amp[i] : 0), registered every clock_in, zero-extended to MIX_W.
  - Maximum value is 1020.
- Simultaneous events: a write and a snd_tick in the same cycle are both applied. The tick uses the old period; the register is updated.

Optional Feature:
- PSG_READY_EN defined:
  - An accepted write drops ready to 0 for exactly READY_CYCLES clock_in cycles, then ready returns to 1.
  - A write with we=1 while ready=0 is ignored entirely, with no register or latch change.
  - Reset forces ready=1 and clears the busy counter.
- Not defined: ready is constant 1 and every we=1 cycle is accepted.

Test Plan:
- Reset, then 8 snd_tick pulses with no writes → audio=0, ch_out=4'b1111, ready=1.
- Write 8'h8A then 8'h00 (tone0 period=10) and 8'h90 (att0=0), then 40 snd_ticks → ch_out[0] toggles every 10 ticks; audio alternates 255 and 0.
- Write 8'h86, then 8'h9F → tone0 period low nibble=6 and att0=15; audio stays 0 regardless of ch_out[0].
- Write 8'hE4 (white noise, rate 00) then 8'hF0 → LFSR shifts every 16 ticks. The first 4 shifts from 15'h4000 give lfsr 2000, 1000, 0800, 0400, and the noise bit is 0.
- Set tone2 period=4, write 8'hE3 (noise clocked by tone2) → LFSR shifts once every 8 ticks, on each tone2 rising edge.
- With PSG_READY_EN: write 8'h90, then pulse we with 8'h9F at cycle 5 → ignored (att0 stays 0); ready returns to 1 at cycle 32; a write at cycle 32 is accepted.
